// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the hazard scoreboard: counter width,
// write-back latency and the operand-forwarding select encoding.
// Optional feature macro used by the files importing this package:
// HAZARD_FWD_EN (compile in operand forwarding instead of stalling).
package pipe_pkg;

    // Width of one per-register scoreboard counter.
    localparam int CNT_W = 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [1:0]       fwd_t;

    // Cycles from issue until an ALU result is committed to the regfile.
    localparam cnt_t WB_LAT = 2'd3;

    // Operand source selects driven towards the EX stage muxes.
    localparam fwd_t FWD_RF    = 2'd0;  // architectural register file
    localparam fwd_t FWD_EXMEM = 2'd1;  // EX/MEM pipeline register
    localparam fwd_t FWD_MEMWB = 2'd2;  // MEM/WB pipeline register
    localparam fwd_t FWD_WB    = 2'd3;  // write-back bypass

    // Map the remaining cycles-to-commit of a busy source onto the stage
    // that currently holds its value.
    function automatic fwd_t fwd_of_cnt(input cnt_t c);
        fwd_t f;
        case (c)
            2'd3:    f = FWD_EXMEM;
            2'd2:    f = FWD_MEMWB;
            2'd1:    f = FWD_WB;
            default: f = FWD_RF;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle of the ID-stage request and issue-control response signals
// between the decode stage (master) and the hazard scoreboard (slave).
//
// Handshake: this is a combinational request/grant, not a queued channel.
// The master holds id_valid and the id_* fields stable for the whole cycle;
// the slave answers in the same cycle. The instruction is consumed at the
// rising edge only when issue = 1. When stall = 1 the master must present
// the same instruction again next cycle. ex_hold freezes the whole exchange:
// nothing issues and no bubble is produced while it is high.
interface hazard_scoreboard_if #(
    parameter int RW = 5
);
    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_data_src;
    logic [RW-1:0] id_write_select;
    logic          id_write_en;
    logic          ex_hold;

    logic          issue;
    logic          stall;
    logic          bubble;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_data_src,
               id_write_select, id_write_en, ex_hold,
        input  issue, stall, bubble, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_data_src,
               id_write_select, id_write_en, ex_hold,
        output issue, stall, bubble, fwd_a, fwd_b
    );

endinterface

// File: rtl/hazard_scoreboard_src_check.sv
// Per-operand source check: looks up the scoreboard counter of one source
// register and reports whether it is still in flight and, when forwarding
// is compiled in (HAZARD_FWD_EN), which pipeline stage holds its value.
module src_check
    import pipe_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int RW    = 5
) (
    input  logic [RW-1:0]          src_i,
    input  logic                   en_i,
    input  logic [NREGS*CNT_W-1:0] sb_i,
    output logic                   busy_o,
    output logic [1:0]             fwd_o
);

    cnt_t cnt_sel;

    // Pick this source's counter out of the flattened scoreboard.
    always_comb begin
        cnt_sel = sb_i[int'(src_i)*CNT_W +: CNT_W];
    end

    // Register 0 is hardwired zero and therefore never in flight.
    always_comb begin
        busy_o = en_i && (src_i != '0) && (cnt_sel != '0);
    end

`ifdef HAZARD_FWD_EN
    // A busy source is served from whichever stage currently holds it.
    always_comb begin
        fwd_o = busy_o ? fwd_of_cnt(cnt_sel) : FWD_RF;
    end
`else
    // Without forwarding every operand is read from the register file.
    always_comb begin
        fwd_o = FWD_RF;
    end
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue controller between IF/ID and EX. Tracks in-flight ALU writes in a
// per-register countdown scoreboard and decides every cycle whether the
// decoded instruction may issue or must stall with a bubble into EX.
// Optional feature: define HAZARD_FWD_EN to resolve busy sources through
// operand forwarding instead of stalling.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int RW    = 5     // must equal $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,        // synchronous, active-low
    hazard_scoreboard_if.slave     bus,
    output logic [NREGS*CNT_W-1:0] dbg_cnt_o   // scoreboard contents
);

`ifdef HAZARD_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    // Scoreboard: cycles remaining until the writer of each register commits.
    cnt_t cnt_q [NREGS];
    cnt_t cnt_d [NREGS];

    logic [NREGS*CNT_W-1:0] sb_vec;
    logic                   chk_a;
    logic                   chk_b;
    logic                   busy_a;
    logic                   busy_b;
    logic [1:0]             fwd_a_sel;
    logic [1:0]             fwd_b_sel;
    logic                   hazard;
    logic                   stall_w;
    logic                   issue_w;
    logic                   load_w;

    // Flatten the scoreboard so the source checkers can index it directly.
    always_comb begin
        sb_vec = '0;
        for (int r = 0; r < NREGS; r++) begin
            sb_vec[r*CNT_W +: CNT_W] = cnt_q[r];
        end
    end

    // rs1 is always read; rs2 is only read when B is not the immediate.
    always_comb begin
        chk_a = bus.id_valid;
        chk_b = bus.id_valid && !bus.id_data_src;
    end

    src_check #(
        .NREGS (NREGS),
        .RW    (RW)
    ) u_src_a (
        .src_i  (bus.id_rs1),
        .en_i   (chk_a),
        .sb_i   (sb_vec),
        .busy_o (busy_a),
        .fwd_o  (fwd_a_sel)
    );

    src_check #(
        .NREGS (NREGS),
        .RW    (RW)
    ) u_src_b (
        .src_i  (bus.id_rs2),
        .en_i   (chk_b),
        .sb_i   (sb_vec),
        .busy_o (busy_b),
        .fwd_o  (fwd_b_sel)
    );

    // Issue decision; a forwarded source is never a hazard. The check uses
    // the registered counters, so a self-dependency never blocks itself.
    always_comb begin
        hazard  = (busy_a || busy_b) && !FWD_ON;
        stall_w = bus.id_valid && (hazard || bus.ex_hold);
        issue_w = bus.id_valid && !stall_w;
        load_w  = issue_w && bus.id_write_en && (bus.id_write_select != '0);
    end

    // Drive the issue controls; no bubble is injected while EX is frozen.
    always_comb begin
        bus.issue  = issue_w;
        bus.stall  = stall_w;
        bus.bubble = stall_w && !bus.ex_hold;
        bus.fwd_a  = fwd_a_sel;
        bus.fwd_b  = fwd_b_sel;
    end

    // Next scoreboard: count down in-flight writes, then let a newly issued
    // writer reload its destination (youngest writer wins). Frozen on hold.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!bus.ex_hold) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
                if (load_w && (bus.id_write_select == RW'(r))) begin
                    cnt_d[r] = WB_LAT;
                end
            end
        end
    end

    // Scoreboard register; reset discards every in-flight write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Expose the scoreboard for observation.
    always_comb begin
        dbg_cnt_o = sb_vec;
    end

endmodule
